game_round_fsm: RTL and testbench
=================================

// Module: game_round_fsm
// PURPOSE
//  Game-flow sequencer upstream of the pattern generator, timer and scoreboard in the top level.
//  Consumes the authorisation pulse, load pulse, match pulse and timeout pulse.
//  Decides round start, win/lose, level advance, lives and game over.
//  Emits single-cycle command pulses to the random generator, the timer and the score logic.
// PARAMETERS
//  ROUNDS_PER_LEVEL  4  wins required to advance one level (1..15)
//  LIVES             3  losses allowed before game over (1..7)
//  MAX_LEVEL         3  last level index; a win-out at MAX_LEVEL ends the game
// PORTS
//  clk           in   1  system clock, rising edge
//  rst           in   1  asynchronous, active-low reset
//  access_pulse  in   1  1-cycle pulse: user authorised (shaped)
//  user_id       in   4  internal id of the authorising user
//  load_pulse    in   1  1-cycle pulse: user requests next round (shaped Load button)
//  match_pulse   in   1  1-cycle pulse: entered pattern equals target
//  timeout_pulse in   1  1-cycle pulse: round timer expired
//  level         out  2  current level, drives generator and scorer
//  round_cnt     out  4  wins in current level
//  lives         out  3  remaining lives
//  cur_user      out  4  id latched at access
//  gen_load      out  1  1-cycle: load new random pattern
//  timer_restart out  1  1-cycle: reload and start round timer
//  score_inc     out  1  1-cycle: credit cur_user one point
//  game_over     out  1  level: session finished
//  state_o       out  3  encoded FSM state for debug/LEDs
// BEHAVIOUR
//  Reset: state IDLE; level, round_cnt, cur_user = 0; lives = LIVES; all pulses and game_over = 0.
//  All outputs are registered. Pulses are high exactly one cycle, one cycle after the causing input.
//  IDLE:
//   - access_pulse: latch user_id, level=0, round_cnt=0, lives=LIVES -> READY.
//   - All other inputs are ignored.
//  READY:
//   - load_pulse: gen_load=1 and timer_restart=1 -> PLAY.
//  PLAY:
//   - match_pulse -> WIN.
//   - Otherwise timeout_pulse -> LOSE.
//   - Match and timeout in the same cycle: match wins.
//   - load_pulse is ignored.
//  WIN (1 cycle): score_inc=1, then:
//   - round_cnt+1 < ROUNDS_PER_LEVEL: round_cnt++ -> READY.
//   - Else, level < MAX_LEVEL: level++, round_cnt=0 -> READY.
//   - Else: round_cnt=0 -> DONE.
//  LOSE (1 cycle):
//   - lives > 1: lives-- -> READY.
//   - Else: lives=0 -> DONE.
//  DONE:
//   - game_over=1.
//   - access_pulse: relatch user_id and reinit counters as in IDLE -> READY; game_over clears next cycle.
//  Inputs arriving during WIN/LOSE are dropped. No queuing.
//  access_pulse outside IDLE/DONE is ignored; cur_user never changes mid-game.
//  Counters never wrap: level saturates at MAX_LEVEL, lives never goes below 0.
//  Encoding of state_o: IDLE=0, READY=1, PLAY=2, WIN=3, LOSE=4, DONE=5.
//  Reset asserted mid-round returns to IDLE immediately; no pulse is emitted on deassertion.
// STRUCTURE
//  Shared package/header: state encoding constants and the default widths for level, lives and id.
//  One natural sub-module, round_progress_ctr, holds round_cnt, level and lives.
//   - Inputs: init, win, lose.
//   - Outputs: counters, plus level_done and out_of_lives flags.
//   - The FSM keeps next-state logic and pulse generation only.
// TESTING
//  1. rst low, then high; no inputs -> state_o=0, lives=3, all pulses 0 for 20 cycles.
//  2. access(id=5), load -> gen_load and timer_restart pulse once; match -> score_inc once, round_cnt=1, state READY.
//  3. Four wins at level 0 -> level=1, round_cnt=0. Repeat to level 3; fourth win there -> game_over=1.
//  4. Three timeouts -> lives 3,2,1,0, then game_over. New access(id=9) -> cur_user=9, lives=3, READY.
//  5. match and timeout in the same PLAY cycle -> WIN path; lives unchanged.
//  6. rst pulsed low while in PLAY -> immediate IDLE, no score_inc. access(id=2) during PLAY -> cur_user unchanged.

Source files
------------

// File: rtl/game_round_fsm_pkg.sv
// Shared definitions for the game round sequencer: state encoding and the
// default widths of level, round, lives and user id fields.
package game_round_fsm_pkg;

  localparam int LEVEL_W = 2;
  localparam int ROUND_W = 4;
  localparam int LIVES_W = 3;
  localparam int ID_W    = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/game_round_fsm_if.sv
// Event inputs and command/status outputs of the game round sequencer.
interface game_round_fsm_if;
  import game_round_fsm_pkg::*;

  logic               access_pulse;
  logic [ID_W-1:0]    user_id;
  logic               load_pulse;
  logic               match_pulse;
  logic               timeout_pulse;
  logic [LEVEL_W-1:0] level;
  logic [ROUND_W-1:0] round_cnt;
  logic [LIVES_W-1:0] lives;
  logic [ID_W-1:0]    cur_user;
  logic               gen_load;
  logic               timer_restart;
  logic               score_inc;
  logic               game_over;
  logic [STATE_W-1:0] state_o;

  modport master (
    output access_pulse, user_id, load_pulse, match_pulse, timeout_pulse,
    input  level, round_cnt, lives, cur_user, gen_load, timer_restart,
           score_inc, game_over, state_o
  );

  modport slave (
    input  access_pulse, user_id, load_pulse, match_pulse, timeout_pulse,
    output level, round_cnt, lives, cur_user, gen_load, timer_restart,
           score_inc, game_over, state_o
  );
endinterface

// File: rtl/game_round_fsm_round_progress_ctr.sv
// Round, level and lives bookkeeping; updates on init, on the win cycle and
// on the lose cycle, and reports when the level or the lives are exhausted.
module round_progress_ctr
  import game_round_fsm_pkg::*;
#(
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int LIVES            = 3,
  parameter int MAX_LEVEL        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               win,
  input  logic               lose,
  output logic [ROUND_W-1:0] round_cnt,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               level_done,
  output logic               out_of_lives
);

  localparam logic [ROUND_W:0]   ROUNDS_C    = (ROUND_W+1)'(ROUNDS_PER_LEVEL);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL_C = LEVEL_W'(MAX_LEVEL);
  localparam logic [LIVES_W-1:0] LIVES_C     = LIVES_W'(LIVES);

  // One extra bit so round_cnt+1 cannot wrap before the compare.
  assign level_done   = (({1'b0, round_cnt} + (ROUND_W+1)'(1)) >= ROUNDS_C);
  assign out_of_lives = (lives <= LIVES_W'(1));

  // Counter registers: init has priority, then win, then lose.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_cnt <= '0;
      level     <= '0;
      lives     <= LIVES_C;
    end else if (init) begin
      round_cnt <= '0;
      level     <= '0;
      lives     <= LIVES_C;
    end else if (win) begin
      if (!level_done) begin
        round_cnt <= round_cnt + ROUND_W'(1);
      end else if (level < MAX_LEVEL_C) begin
        level     <= level + LEVEL_W'(1);
        round_cnt <= '0;
      end else begin
        round_cnt <= '0;
      end
    end else if (lose) begin
      if (!out_of_lives) begin
        lives <= lives - LIVES_W'(1);
      end else begin
        lives <= '0;
      end
    end
  end

endmodule

// File: rtl/game_round_fsm.sv
// Game-flow sequencer: round start, win/lose resolution, level advance and
// game over, emitting one-cycle commands to generator, timer and scorer.
module game_round_fsm
  import game_round_fsm_pkg::*;
#(
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int LIVES            = 3,
  parameter int MAX_LEVEL        = 3
) (
  input  logic              clk,
  input  logic              rst,
  game_round_fsm_if.slave   bus
);

  localparam logic [LEVEL_W-1:0] MAX_LEVEL_C = LEVEL_W'(MAX_LEVEL);

  state_t             state_r, state_nxt_s;
  logic               init_s, win_s, lose_s;
  logic               gen_nxt_s, score_nxt_s;
  logic               gen_load_r, timer_restart_r, score_inc_r, game_over_r;
  logic [ID_W-1:0]    cur_user_r;
  logic [ROUND_W-1:0] round_cnt_s;
  logic [LEVEL_W-1:0] level_s;
  logic [LIVES_W-1:0] lives_s;
  logic               level_done_s, out_of_lives_s;

  assign win_s  = (state_r == S_WIN);
  assign lose_s = (state_r == S_LOSE);

  round_progress_ctr #(
    .ROUNDS_PER_LEVEL (ROUNDS_PER_LEVEL),
    .LIVES            (LIVES),
    .MAX_LEVEL        (MAX_LEVEL)
  ) u_progress (
    .clk          (clk),
    .rst          (rst),
    .init         (init_s),
    .win          (win_s),
    .lose         (lose_s),
    .round_cnt    (round_cnt_s),
    .level        (level_s),
    .lives        (lives_s),
    .level_done   (level_done_s),
    .out_of_lives (out_of_lives_s)
  );

  // Next-state decode and the pulse requests registered on the same edge.
  always_comb begin
    state_nxt_s = state_r;
    init_s      = 1'b0;
    gen_nxt_s   = 1'b0;
    score_nxt_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.access_pulse) begin
          init_s      = 1'b1;
          state_nxt_s = S_READY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_READY: begin
        if (bus.load_pulse) begin
          gen_nxt_s   = 1'b1;
          state_nxt_s = S_PLAY;
        end else begin
          state_nxt_s = S_READY;
        end
      end
      S_PLAY: begin
        if (bus.match_pulse) begin
          score_nxt_s = 1'b1;
          state_nxt_s = S_WIN;
        end else if (bus.timeout_pulse) begin
          state_nxt_s = S_LOSE;
        end else begin
          state_nxt_s = S_PLAY;
        end
      end
      // Counters still hold pre-win values here, so the flags see the old round.
      S_WIN: begin
        if (level_done_s && (level_s == MAX_LEVEL_C)) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_READY;
        end
      end
      S_LOSE: begin
        if (out_of_lives_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_READY;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, command pulses, game_over and the latched user id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= S_IDLE;
      gen_load_r      <= 1'b0;
      timer_restart_r <= 1'b0;
      score_inc_r     <= 1'b0;
      game_over_r     <= 1'b0;
      cur_user_r      <= '0;
    end else begin
      state_r         <= state_nxt_s;
      gen_load_r      <= gen_nxt_s;
      timer_restart_r <= gen_nxt_s;
      score_inc_r     <= score_nxt_s;
      game_over_r     <= (state_nxt_s == S_DONE);
      if (init_s) begin
        cur_user_r <= bus.user_id;
      end
    end
  end

  assign bus.state_o       = state_r;
  assign bus.gen_load      = gen_load_r;
  assign bus.timer_restart = timer_restart_r;
  assign bus.score_inc     = score_inc_r;
  assign bus.game_over     = game_over_r;
  assign bus.cur_user      = cur_user_r;
  assign bus.level         = level_s;
  assign bus.round_cnt     = round_cnt_s;
  assign bus.lives         = lives_s;

endmodule

// File: tb/tb_game_round_fsm.sv
// Self-checking bench for game_round_fsm: directed scenarios plus a random
// run, all compared against a rule-level model of the game flow.
module tb_game_round_fsm;

  localparam int RPL   = 4;
  localparam int NLIV  = 3;
  localparam int MAXL  = 3;
  localparam int P_IDLE = 0, P_READY = 1, P_PLAY = 2, P_WIN = 3, P_LOSE = 4, P_DONE = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  game_round_fsm_if bus();

  game_round_fsm #(.ROUNDS_PER_LEVEL(RPL), .LIVES(NLIV), .MAX_LEVEL(MAXL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model of the game in plain integers
  int       m_phase, m_level, m_round, m_lives;
  logic [3:0] m_user;
  logic     m_gen, m_tmr, m_score, m_over;

  task automatic model_reset();
    m_phase = P_IDLE; m_level = 0; m_round = 0; m_lives = NLIV; m_user = 4'd0;
    m_gen = 1'b0; m_tmr = 1'b0; m_score = 1'b0; m_over = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic [3:0] id, input logic ld,
                            input logic m, input logic t);
    m_gen = 1'b0; m_tmr = 1'b0; m_score = 1'b0;
    if (m_phase == P_IDLE || m_phase == P_DONE) begin
      if (a) begin
        m_user = id; m_level = 0; m_round = 0; m_lives = NLIV; m_phase = P_READY;
      end
    end else if (m_phase == P_READY) begin
      if (ld) begin m_gen = 1'b1; m_tmr = 1'b1; m_phase = P_PLAY; end
    end else if (m_phase == P_PLAY) begin
      if (m)      begin m_score = 1'b1; m_phase = P_WIN; end
      else if (t) m_phase = P_LOSE;
    end else if (m_phase == P_WIN) begin
      if (m_round + 1 < RPL)     begin m_round = m_round + 1; m_phase = P_READY; end
      else if (m_level < MAXL)   begin m_level = m_level + 1; m_round = 0; m_phase = P_READY; end
      else                       begin m_round = 0; m_phase = P_DONE; end
    end else begin
      if (m_lives > 1) begin m_lives = m_lives - 1; m_phase = P_READY; end
      else             begin m_lives = 0; m_phase = P_DONE; end
    end
    m_over = (m_phase == P_DONE);
  endtask

  function automatic logic [19:0] exp_vec();
    return {3'(m_phase), 2'(m_level), 4'(m_round), 3'(m_lives), m_user,
            m_gen, m_tmr, m_score, m_over};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.state_o, bus.level, bus.round_cnt, bus.lives, bus.cur_user,
            bus.gen_load, bus.timer_restart, bus.score_inc, bus.game_over};
  endfunction

  // One clock: drive inputs, advance model at the edge, return 1 time unit later
  task automatic cycle(input logic a, input logic [3:0] id, input logic ld,
                       input logic m, input logic t);
    bus.access_pulse = a; bus.user_id = id; bus.load_pulse = ld;
    bus.match_pulse = m; bus.timeout_pulse = t;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step(a, id, ld, m, t);
    #1;
  endtask

  task automatic test_reset();
    bus.access_pulse = 1'b0; bus.user_id = 4'd0; bus.load_pulse = 1'b0;
    bus.match_pulse = 1'b0; bus.timeout_pulse = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_asserted got=%h exp=%h", dut_vec(), exp_vec());
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({bus.state_o, bus.lives, bus.gen_load, bus.timer_restart, bus.score_inc, bus.game_over}
          !== {3'd0, 3'd3, 4'b0000}) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_first_round();
    cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL access got=%h exp=%h", dut_vec(), exp_vec());
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({bus.gen_load, bus.timer_restart, bus.state_o} !== {2'b11, 3'd2}) begin
      bad++; $display("FAIL load_pulse got=%b%b/%0d exp=11/2", bus.gen_load, bus.timer_restart, bus.state_o);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.gen_load, bus.timer_restart} !== 2'b00) begin
      bad++; $display("FAIL load_once got=%b%b exp=00", bus.gen_load, bus.timer_restart);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.score_inc, bus.state_o} !== {1'b1, 3'd3}) begin
      bad++; $display("FAIL score_pulse got=%b/%0d exp=1/3", bus.score_inc, bus.state_o);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.state_o, bus.round_cnt, bus.score_inc, bus.cur_user} !== {3'd1, 4'd1, 1'b0, 4'd5}) begin
      bad++; $display("FAIL after_win got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_level_up();
    int wins;
    for (int w = 1; w < 16; w++) begin
      cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      wins = w + 1;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL win_seq wins=%0d got=%h exp=%h", wins, dut_vec(), exp_vec());
      end
      if (wins % 4 == 0 && wins < 16) begin
        total++;
        if ({bus.level, bus.round_cnt} !== {2'(wins / 4), 4'd0}) begin
          bad++; $display("FAIL level_adv wins=%0d got=%0d/%0d exp=%0d/0", wins, bus.level, bus.round_cnt, wins / 4);
        end
      end
    end
    total++;
    if ({bus.game_over, bus.state_o, bus.level, bus.round_cnt} !== {1'b1, 3'd5, 2'd3, 4'd0}) begin
      bad++; $display("FAIL win_out got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_lives();
    cycle(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus.lives !== 3'(2 - k) || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL lives k=%0d got=%0d exp=%0d", k, bus.lives, 2 - k);
      end
    end
    total++;
    if ({bus.game_over, bus.state_o} !== {1'b1, 3'd5}) begin
      bad++; $display("FAIL lose_out got=%b/%0d exp=1/5", bus.game_over, bus.state_o);
    end
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.cur_user, bus.lives, bus.state_o, bus.game_over} !== {4'd9, 3'd3, 3'd1, 1'b0}) begin
      bad++; $display("FAIL restart got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_match_timeout();
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    total++;
    if ({bus.score_inc, bus.state_o} !== {1'b1, 3'd3}) begin
      bad++; $display("FAIL both_win got=%b/%0d exp=1/3", bus.score_inc, bus.state_o);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.lives, bus.round_cnt, bus.state_o} !== {3'd3, 4'd1, 3'd1}) begin
      bad++; $display("FAIL both_lives got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    bus.match_pulse = 1'b1;
    #1;
    model_reset();
    total++;
    if ({bus.state_o, bus.score_inc, bus.cur_user} !== {3'd0, 1'b0, 4'd0}) begin
      bad++; $display("FAIL async_rst got=%h exp=%h", dut_vec(), exp_vec());
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus.score_inc !== 1'b0 || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rst_release cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.cur_user, bus.state_o} !== {4'd4, 3'd2}) begin
      bad++; $display("FAIL access_in_play got=%0d/%0d exp=4/2", bus.cur_user, bus.state_o);
    end
  endtask

  task automatic test_random();
    logic a, ld, m, t;
    logic [3:0] id;
    for (int i = 0; i < 3000; i++) begin
      a  = ($urandom_range(0, 7) == 0);
      ld = ($urandom_range(0, 2) == 0);
      m  = ($urandom_range(0, 4) == 0);
      t  = ($urandom_range(0, 4) == 0);
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      cycle(a, id, ld, m, t);
      rst = 1'b1;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_level_up();
    test_lives();
    test_match_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
